shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 a_valid  input  1  requester A presents an operation.
REQ-005 a_data  input  32  requester A operand.
REQ-006 a_amt  input  5  requester A logical-right shift amount.
REQ-007 a_ready  output  1  requester A operation accepted this cycle.
REQ-008 b_valid, b_data, b_amt, b_ready SHALL mirror REQ-004..REQ-007 for requester B.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_data  output  32  registered shift result.
REQ-011 out_id  output  1  source of the result: 0 = A, 1 = B.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 grant_cnt_a, grant_cnt_b  output  8 each  accepted-operation counters, wrapping modulo 256.

Function
REQ-014 A single internal 32-bit logical right barrel shifter SHALL be shared by both requesters; zero fill, amounts 0..31.
REQ-015 Per-cycle transfer:
  - out_fire = out_valid & out_ready.
  - can_accept = !out_valid | out_ready.
REQ-016 Grant rules, applied only when can_accept = 1:
  - Only one of a_valid/b_valid high: that requester is granted.
  - Both high: the requester selected by priority pointer prio is granted (prio=0 favours A, prio=1 favours B).
REQ-017 When can_accept = 0, a_ready and b_ready SHALL both be 0.
REQ-018 Exactly one requester's ready is high when a grant occurs; ready is never high without the matching valid.
REQ-019 a_ready/b_ready SHALL be combinational from the valids, prio, out_valid and out_ready.
REQ-020 Requesters SHALL hold valid, data and amt stable until ready is seen; the arbiter samples operands only in the grant cycle.
REQ-021 On a grant, the following SHALL be updated at the next edge:
  - out_data <= granted data >> granted amt.
  - out_id <= granted requester.
  - out_valid <= 1.
REQ-022 Latency SHALL be exactly one cycle from grant to out_valid; sustained throughput is one result per cycle while out_ready = 1.
REQ-023 out_fire with no new grant SHALL clear out_valid at the next edge.
REQ-024 out_fire together with a grant SHALL replace the result in the same edge, with no bubble.
REQ-025 While out_valid = 1 and out_ready = 0:
  - out_data, out_id and out_valid SHALL hold.
  - No grant occurs.
REQ-026 Priority pointer update:
  - On a contested grant (both valid), prio <= !granted_id.
  - On an uncontested grant, prio <= !granted_id.
  - With no grant, prio holds.
REQ-027 grant_cnt_a increments by 1 on each A grant and grant_cnt_b on each B grant; 255 wraps to 0.
REQ-028 amt = 0 SHALL pass data unchanged; amt = 31 SHALL leave only bit 31 in bit 0.

Reset
REQ-029 While reset = 0 at a rising edge, the following SHALL be set: out_valid=0, out_data=0, out_id=0, prio=0, grant_cnt_a=0, grant_cnt_b=0.
REQ-030 During a reset cycle, a_ready and b_ready SHALL be 0 and no grant is counted.
REQ-031 Reset asserted mid-operation SHALL discard any held result without an out_fire; the first cycle after release behaves as an empty unit.

Verification
REQ-032 Single A request:
  - Stimulus: reset released, a_valid=1, a_data=0x80000000, a_amt=31, out_ready=1.
  - Response: a_ready=1 that cycle; next cycle out_valid=1, out_data=0x00000001, out_id=0, grant_cnt_a=1.
REQ-033 Contention:
  - Stimulus: both requesters valid continuously, a_data=0xFFFF0000 amt 16, b_data=0x12345678 amt 4, out_ready=1.
  - Response: results alternate A,B,A,B…; values 0x0000FFFF, 0x01234567; one result per cycle.
REQ-034 Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with a result held and a_valid=1.
  - Response: a_ready=0 and out_data stable all 3 cycles.
  - Then: out_ready=1; the new result appears the following cycle, with no lost or duplicated result.
REQ-035 Zero shift:
  - Stimulus: b_valid=1, b_data=0xDEADBEEF, b_amt=0.
  - Response: out_data=0xDEADBEEF, out_id=1.
REQ-036 Counter wrap:
  - Stimulus: 256 A grants.
  - Response: grant_cnt_a returns to 0; grant_cnt_b unchanged.
REQ-037 Reset mid-operation:
  - Stimulus: reset=0 while out_valid=1 and out_ready=0.
  - Response: next cycle out_valid=0, all counters 0, prio=0.
  - Then: a contested request after release grants A first.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Bundle of requester, result and counter signals for shift_arbiter.
// master: requesters and result consumer side; slave: the arbiter itself.
interface shift_arbiter_if;
  logic        a_valid;
  logic [31:0] a_data;
  logic [4:0]  a_amt;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_data;
  logic [4:0]  b_amt;
  logic        b_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_id;
  logic        out_ready;
  logic [7:0]  grant_cnt_a;
  logic [7:0]  grant_cnt_b;

  modport master (
    output a_valid, a_data, a_amt, b_valid, b_data, b_amt, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_id, grant_cnt_a, grant_cnt_b
  );

  modport slave (
    input  a_valid, a_data, a_amt, b_valid, b_data, b_amt, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_id, grant_cnt_a, grant_cnt_b
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit logical right shifter.
// Results land in a single output register; a new grant may replace a result
// in the same cycle it is consumed, giving one result per cycle.
module shift_arbiter (
  input logic             clock,
  input logic             reset,
  shift_arbiter_if.slave  bus
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_id_q, out_id_d;
  logic        prio_q, prio_d;
  logic [7:0]  cnt_a_q, cnt_a_d;
  logic [7:0]  cnt_b_q, cnt_b_d;

  logic        can_accept;
  logic        grant_a;
  logic        grant_b;
  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic [31:0] shifted;

  // Arbitration: readies are suppressed during reset and while a held result is stalled.
  always_comb begin
    can_accept = reset & (~out_valid_q | bus.out_ready);
    grant_a    = can_accept & bus.a_valid & (~bus.b_valid | ~prio_q);
    grant_b    = can_accept & bus.b_valid & (~bus.a_valid | prio_q);
    sel_data   = grant_b ? bus.b_data : bus.a_data;
    sel_amt    = grant_b ? bus.b_amt : bus.a_amt;
  end

  // Shared log-stage barrel shifter, zero fill.
  always_comb begin
    shifted = sel_data;
    for (int i = 0; i < 5; i++) begin
      if (sel_amt[i]) shifted = shifted >> (1 << i);
    end
  end

  // Next-state: load on grant, drain on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    prio_d      = prio_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    if (grant_a || grant_b) begin
      out_valid_d = 1'b1;
      out_data_d  = shifted;
      out_id_d    = grant_b;
      prio_d      = ~grant_b;
      if (grant_a) cnt_a_d = cnt_a_q + 8'd1;
      if (grant_b) cnt_b_d = cnt_b_q + 8'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_id_q    <= 1'b0;
      prio_q      <= 1'b0;
      cnt_a_q     <= 8'd0;
      cnt_b_q     <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      prio_q      <= prio_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_id      = out_id_q;
  assign bus.grant_cnt_a = cnt_a_q;
  assign bus.grant_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, single grant, contention,
// backpressure, zero shift, counter wrap and reset mid-operation.
module tb_shift_arbiter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  shift_arbiter_if bus ();

  shift_arbiter u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.a_valid = 1'b1; bus.a_data = 32'hFFFF_FFFF; bus.a_amt = 5'd0;
    bus.b_valid = 1'b1; bus.b_data = 32'hFFFF_FFFF; bus.b_amt = 5'd0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got a=%b b=%b want a=0 b=0", bus.a_ready, bus.b_ready);
    end
    tick();
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_id !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b d=%h id=%b want v=0 d=00000000 id=0",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    n_checks++;
    if (bus.grant_cnt_a !== 8'd0 || bus.grant_cnt_b !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got a=%0d b=%0d want 0 0", bus.grant_cnt_a, bus.grant_cnt_b);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic test_single_a();
    reset = 1'b1;
    bus.a_valid = 1'b1; bus.a_data = 32'h8000_0000; bus.a_amt = 5'd31;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0001 || bus.out_id !== 1'b0 ||
        bus.grant_cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL single_result: got v=%b d=%h id=%b cnt=%0d want v=1 d=00000001 id=0 cnt=1",
               bus.out_valid, bus.out_data, bus.out_id, bus.grant_cnt_a);
    end
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready_drop: got %b want 0", bus.a_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  // prio is 1 after the single A grant, so contention starts with B.
  task automatic test_contention();
    logic        exp_id;
    logic [31:0] exp_d;
    bus.a_valid = 1'b1; bus.a_data = 32'hFFFF_0000; bus.a_amt = 5'd16;
    bus.b_valid = 1'b1; bus.b_data = 32'h1234_5678; bus.b_amt = 5'd4;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_id = (i % 2 == 0);
      exp_d  = exp_id ? 32'h0123_4567 : 32'h0000_FFFF;
      #1;
      n_checks++;
      if (bus.a_ready !== ~exp_id || bus.b_ready !== exp_id) begin
        n_fail++;
        $display("FAIL contend_ready[%0d]: got a=%b b=%b want a=%b b=%b",
                 i, bus.a_ready, bus.b_ready, ~exp_id, exp_id);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_data !== exp_d) begin
        n_fail++;
        $display("FAIL contend_result[%0d]: got v=%b id=%b d=%h want v=1 id=%b d=%h",
                 i, bus.out_valid, bus.out_id, bus.out_data, exp_id, exp_d);
      end
    end
    n_checks++;
    if (bus.grant_cnt_a !== 8'd4 || bus.grant_cnt_b !== 8'd3) begin
      n_fail++;
      $display("FAIL contend_cnt: got a=%0d b=%0d want a=4 b=3", bus.grant_cnt_a, bus.grant_cnt_b);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.a_valid = 1'b1; bus.a_data = 32'h0000_F000; bus.a_amt = 5'd12;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.a_data = 32'hABCD_0000; bus.a_amt = 5'd16;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_000F || bus.grant_cnt_a !== 8'd5) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b d=%h cnt=%0d want v=1 d=0000000f cnt=5",
               bus.out_valid, bus.out_data, bus.grant_cnt_a);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.a_ready);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_000F || bus.grant_cnt_a !== 8'd5) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h cnt=%0d want v=1 d=0000000f cnt=5",
                 i, bus.out_valid, bus.out_data, bus.grant_cnt_a);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 1", bus.a_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_ABCD || bus.grant_cnt_a !== 8'd6) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b d=%h cnt=%0d want v=1 d=0000abcd cnt=6",
               bus.out_valid, bus.out_data, bus.grant_cnt_a);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.grant_cnt_a !== 8'd6) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=6", bus.out_valid, bus.grant_cnt_a);
    end
  endtask

  task automatic test_zero_shift();
    bus.b_valid = 1'b1; bus.b_data = 32'hDEAD_BEEF; bus.b_amt = 5'd0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_ready: got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready);
    end
    tick();
    bus.b_valid = 1'b0;
    n_checks++;
    if (bus.out_data !== 32'hDEAD_BEEF || bus.out_id !== 1'b1 || bus.grant_cnt_b !== 8'd4) begin
      n_fail++;
      $display("FAIL zero_result: got d=%h id=%b cntb=%0d want d=deadbeef id=1 cntb=4",
               bus.out_data, bus.out_id, bus.grant_cnt_b);
    end
    tick();
  endtask

  // cnt_a starts at 6; 250 grants reach 255 and then wrap to 0.
  task automatic test_counter_wrap();
    logic [31:0] src;
    logic [31:0] exp_d;
    bus.a_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      src = 32'h8000_0000 | 32'(i);
      bus.a_data = src;
      bus.a_amt  = 5'(i % 32);
      exp_d = src >> (i % 32);
      tick();
      n_checks++;
      if (bus.out_data !== exp_d || bus.out_id !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_data[%0d]: got d=%h id=%b want d=%h id=0",
                 i, bus.out_data, bus.out_id, exp_d);
      end
      if (i == 248) begin
        n_checks++;
        if (bus.grant_cnt_a !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: got %0d want 255", bus.grant_cnt_a);
        end
      end
    end
    bus.a_valid = 1'b0;
    n_checks++;
    if (bus.grant_cnt_a !== 8'd0 || bus.grant_cnt_b !== 8'd4) begin
      n_fail++;
      $display("FAIL wrap_zero: got a=%0d b=%0d want a=0 b=4", bus.grant_cnt_a, bus.grant_cnt_b);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.a_valid = 1'b1; bus.a_data = 32'h0000_00F0; bus.a_amt = 5'd4;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.b_valid = 1'b1; bus.b_data = 32'h1234_5678; bus.b_amt = 5'd4;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_ready: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.grant_cnt_a !== 8'd0 ||
        bus.grant_cnt_b !== 8'd0) begin
      n_fail++;
      $display("FAIL rmid_clear: got v=%b d=%h a=%0d b=%0d want v=0 d=00000000 a=0 b=0",
               bus.out_valid, bus.out_data, bus.grant_cnt_a, bus.grant_cnt_b);
    end
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_first_ready: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
    end
    tick();
    n_checks++;
    if (bus.out_id !== 1'b0 || bus.out_data !== 32'h0000_000F || bus.grant_cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL rmid_first: got id=%b d=%h cnt=%0d want id=0 d=0000000f cnt=1",
               bus.out_id, bus.out_data, bus.grant_cnt_a);
    end
    #1;
    n_checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_second_ready: got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready);
    end
    tick();
    n_checks++;
    if (bus.out_id !== 1'b1 || bus.out_data !== 32'h0123_4567 || bus.grant_cnt_b !== 8'd1) begin
      n_fail++;
      $display("FAIL rmid_second: got id=%b d=%h cnt=%0d want id=1 d=01234567 cnt=1",
               bus.out_id, bus.out_data, bus.grant_cnt_b);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.a_valid = 1'b0; bus.a_data = 32'd0; bus.a_amt = 5'd0;
    bus.b_valid = 1'b0; bus.b_data = 32'd0; bus.b_amt = 5'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_a();
    test_contention();
    test_backpressure();
    test_zero_shift();
    test_counter_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
